// File: rtl/nv_pdp_rdma_rsp_elastic_pipe_pkg.sv
// rtl/nv_pdp_rdma_rsp_elastic_pipe_pkg.sv - shared PDP RDMA response types and width helpers
// The response payload is 512 data bits followed by a 2-bit half-line mask.
package nv_pdp_rdma_pkg;

  localparam int RSP_PD_W = 514;

  typedef struct packed {
    logic [511:0] data;
    logic [1:0]   mask;
  } rsp_pd_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nv_pdp_rdma_rsp_elastic_pipe_if.sv
// rtl/nv_pdp_rdma_rsp_elastic_pipe_if.sv - d0/d1 response handshake bundle with status outputs
// The pipe sits on the slave side; the producer/consumer environment uses master.
interface nv_pdp_rdma_rsp_elastic_pipe_if
  import nv_pdp_rdma_pkg::*;
#(
  parameter int DW    = RSP_PD_W,
  parameter int DEPTH = 2
);
  localparam int CW = cnt_w(DEPTH);

  logic          rsp_flush;
  logic          rsp_valid_d0;
  logic [DW-1:0] rsp_pd_d0;
  logic          rsp_ready_d0;
  logic          rsp_valid_d1;
  logic [DW-1:0] rsp_pd_d1;
  logic          rsp_ready_d1;
  logic [CW-1:0] rsp_occ;
  logic          rsp_afull;

  modport master (
    output rsp_flush, rsp_valid_d0, rsp_pd_d0, rsp_ready_d1,
    input  rsp_ready_d0, rsp_valid_d1, rsp_pd_d1, rsp_occ, rsp_afull
  );

  modport slave (
    input  rsp_flush, rsp_valid_d0, rsp_pd_d0, rsp_ready_d1,
    output rsp_ready_d0, rsp_valid_d1, rsp_pd_d1, rsp_occ, rsp_afull
  );

endinterface

// File: rtl/nv_pdp_rdma_rsp_elastic_pipe_wrap_ptr.sv
// rtl/nv_pdp_rdma_rsp_elastic_pipe_wrap_ptr.sv - buffer index register with explicit wrap at DEPTH-1
// Wraps by compare rather than overflow so non-power-of-two depths index correctly.
module nv_pdp_rdma_wrap_ptr #(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/nv_pdp_rdma_rsp_elastic_pipe.sv
// rtl/nv_pdp_rdma_rsp_elastic_pipe.sv - DEPTH-entry elastic pipe for the PDP RDMA read-response path
// Ready, valid, occupancy and afull all come straight from flops; no d0->d1 combinational path.
module nv_pdp_rdma_rsp_elastic_pipe
  import nv_pdp_rdma_pkg::*;
#(
  parameter int DW        = RSP_PD_W,
  parameter int DEPTH     = 2,
  parameter int AFULL_LVL = 1
) (
  input logic                           nvdla_core_clk,
  input logic                           nvdla_core_rstn,
  nv_pdp_rdma_rsp_elastic_pipe_if.slave rsp
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_nxt;
  logic          ready_q;
  logic          afull_q;
  logic          push;
  logic          pop;

  assign push = rsp.rsp_valid_d0 & ready_q;
  assign pop  = rsp.rsp_valid_d1 & rsp.rsp_ready_d1;

  always_comb begin
    occ_nxt = occ;
    if (push && !pop) begin
      occ_nxt = occ + 1'b1;
    end else if (pop && !push) begin
      occ_nxt = occ - 1'b1;
    end
  end

  // Flush outranks push/pop: whatever was offered in the flush cycle is discarded.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      occ     <= '0;
      ready_q <= 1'b1;
      afull_q <= 1'b0;
    end else if (rsp.rsp_flush) begin
      occ     <= '0;
      ready_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      occ     <= occ_nxt;
      ready_q <= (occ_nxt < CW'(DEPTH));
      afull_q <= (occ_nxt >= CW'(AFULL_LVL));
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (push && !rsp.rsp_flush) begin
      mem[wr_ptr] <= rsp.rsp_pd_d0;
    end
  end

  nv_pdp_rdma_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .clr             (rsp.rsp_flush),
    .inc             (push),
    .ptr             (wr_ptr)
  );

  nv_pdp_rdma_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .clr             (rsp.rsp_flush),
    .inc             (pop),
    .ptr             (rd_ptr)
  );

  assign rsp.rsp_ready_d0 = ready_q;
  assign rsp.rsp_valid_d1 = (occ != '0);
  assign rsp.rsp_pd_d1    = mem[rd_ptr];
  assign rsp.rsp_occ      = occ;
  assign rsp.rsp_afull    = afull_q;

endmodule

// File: tb/tb_nv_pdp_rdma_rsp_elastic_pipe.sv
// tb/tb_nv_pdp_rdma_rsp_elastic_pipe.sv - directed bench for the PDP RDMA response elastic pipe
// DEPTH=2 instance runs a hand-computed vector table; DEPTH=3 instance runs against a queue model.
module tb_nv_pdp_rdma_rsp_elastic_pipe;

  localparam int DW = 514;

  logic clk;
  logic rstn;
  int   nchk;
  int   nerr;

  nv_pdp_rdma_rsp_elastic_pipe_if #(.DW(DW), .DEPTH(2)) u2 ();
  nv_pdp_rdma_rsp_elastic_pipe_if #(.DW(DW), .DEPTH(3)) u3 ();

  nv_pdp_rdma_rsp_elastic_pipe #(.DW(DW), .DEPTH(2), .AFULL_LVL(1)) dut2 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .rsp             (u2.slave)
  );

  nv_pdp_rdma_rsp_elastic_pipe #(.DW(DW), .DEPTH(3), .AFULL_LVL(2)) dut3 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .rsp             (u3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      nchk++;
      if (u2.rsp_occ > 2) begin
        nerr++;
        $display("FAIL occ2_bound: got %0d expected <= 2", u2.rsp_occ);
      end
      nchk++;
      if (u3.rsp_occ > 3) begin
        nerr++;
        $display("FAIL occ3_bound: got %0d expected <= 3", u3.rsp_occ);
      end
    end
  end

  typedef struct {
    logic        fl;
    logic        v;
    logic [15:0] pd;
    logic        r1;
    logic        e_v;
    logic [15:0] e_pd;
    logic        e_rdy;
    logic [1:0]  e_occ;
    logic        e_af;
  } vec_t;

  vec_t tbl[14];

  logic [DW-1:0] m_q[$];

  // One DEPTH=3 cycle: drive inputs, compare outputs with the queue model, advance model and clock.
  task automatic cyc3(input logic v, input logic [DW-1:0] pd, input logic r1, input logic fl);
    logic pu;
    logic po;
    u3.rsp_flush    = fl;
    u3.rsp_valid_d0 = v;
    u3.rsp_pd_d0    = pd;
    u3.rsp_ready_d1 = r1;
    chk("d3_valid", DW'(u3.rsp_valid_d1), DW'(m_q.size() != 0));
    chk("d3_ready", DW'(u3.rsp_ready_d0), DW'(m_q.size() < 3));
    chk("d3_occ",   DW'(u3.rsp_occ),      DW'(m_q.size()));
    chk("d3_afull", DW'(u3.rsp_afull),    DW'(m_q.size() >= 2));
    if (m_q.size() != 0) chk("d3_pd", u3.rsp_pd_d1, m_q[0]);
    if (fl) begin
      m_q.delete();
    end else begin
      po = (m_q.size() != 0) && r1;
      pu = v && (m_q.size() < 3);
      if (po) void'(m_q.pop_front());
      if (pu) m_q.push_back(pd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          hold;
    logic          v;
    logic          r;
    logic          acc;
    logic [DW-1:0] cur;
    int            sent;

    nchk = 0;
    nerr = 0;
    rstn = 1'b0;
    u2.rsp_flush = 1'b0; u2.rsp_valid_d0 = 1'b0; u2.rsp_pd_d0 = '0; u2.rsp_ready_d1 = 1'b0;
    u3.rsp_flush = 1'b0; u3.rsp_valid_d0 = 1'b0; u3.rsp_pd_d0 = '0; u3.rsp_ready_d1 = 1'b0;

    //          fl v  pd      r1 e_v e_pd    rdy occ af
    tbl[0]  = '{0, 1, 16'hA1, 0, 0, 16'h00, 1, 0, 0};
    tbl[1]  = '{0, 1, 16'hB2, 0, 1, 16'hA1, 1, 1, 1};
    tbl[2]  = '{0, 0, 16'h00, 0, 1, 16'hA1, 0, 2, 1};
    tbl[3]  = '{0, 0, 16'h00, 1, 1, 16'hA1, 0, 2, 1};
    tbl[4]  = '{0, 1, 16'hC3, 0, 1, 16'hB2, 1, 1, 1};
    tbl[5]  = '{1, 1, 16'hD4, 1, 1, 16'hB2, 0, 2, 1};
    tbl[6]  = '{0, 1, 16'hE5, 0, 0, 16'h00, 1, 0, 0};
    tbl[7]  = '{1, 1, 16'hF6, 0, 1, 16'hE5, 1, 1, 1};
    tbl[8]  = '{0, 1, 16'h77, 1, 0, 16'h00, 1, 0, 0};
    tbl[9]  = '{0, 0, 16'h00, 1, 1, 16'h77, 1, 1, 1};
    tbl[10] = '{0, 1, 16'h88, 0, 0, 16'h00, 1, 0, 0};
    tbl[11] = '{0, 1, 16'h99, 1, 1, 16'h88, 1, 1, 1};
    tbl[12] = '{0, 0, 16'h00, 1, 1, 16'h99, 1, 1, 1};
    tbl[13] = '{0, 0, 16'h00, 0, 0, 16'h00, 1, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", DW'(u2.rsp_ready_d0), DW'(1));
    chk("rst_valid", DW'(u2.rsp_valid_d1), DW'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      u2.rsp_flush    = tbl[i].fl;
      u2.rsp_valid_d0 = tbl[i].v;
      u2.rsp_pd_d0    = DW'(tbl[i].pd);
      u2.rsp_ready_d1 = tbl[i].r1;
      chk($sformatf("v%0d_valid", i), DW'(u2.rsp_valid_d1), DW'(tbl[i].e_v));
      chk($sformatf("v%0d_ready", i), DW'(u2.rsp_ready_d0), DW'(tbl[i].e_rdy));
      chk($sformatf("v%0d_occ", i),   DW'(u2.rsp_occ),      DW'(tbl[i].e_occ));
      chk($sformatf("v%0d_afull", i), DW'(u2.rsp_afull),    DW'(tbl[i].e_af));
      if (tbl[i].e_v) chk($sformatf("v%0d_pd", i), u2.rsp_pd_d1, DW'(tbl[i].e_pd));
      @(posedge clk);
      #1;
    end
    u2.rsp_flush = 1'b0; u2.rsp_valid_d0 = 1'b0; u2.rsp_pd_d0 = '0; u2.rsp_ready_d1 = 1'b0;

    // Full-rate streaming: occ should settle at 1 with ready held high.
    for (int i = 0; i < 100; i++) cyc3(1'b1, DW'(1000 + i), 1'b1, 1'b0);
    cyc3(1'b0, '0, 1'b1, 1'b0);
    cyc3(1'b0, '0, 1'b1, 1'b0);

    // Fill to full, pop once, then push+pop together at occ=2 across the wrap.
    for (int i = 0; i < 3; i++) cyc3(1'b1, DW'(200 + i), 1'b0, 1'b0);
    cyc3(1'b1, DW'(203), 1'b0, 1'b0);
    cyc3(1'b0, DW'(203), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc3(1'b1, DW'(203 + i), 1'b1, 1'b0);

    hold = 1'b0;
    cur  = DW'($urandom);
    sent = 0;
    for (int k = 0; k < 80 && sent < 20; k++) begin
      v   = hold | ($urandom_range(0, 1) == 1);
      r   = ($urandom_range(0, 3) != 0);
      acc = v && (m_q.size() < 3);
      cyc3(v, cur, r, 1'b0);
      if (acc) begin
        sent++;
        cur  = DW'($urandom);
        hold = 1'b0;
      end else begin
        hold = v;
      end
    end
    for (int i = 0; i < 6; i++) cyc3(1'b0, '0, 1'b1, 1'b0);

    // Flush at occ=2 with an item offered.
    cyc3(1'b1, DW'(300), 1'b0, 1'b0);
    cyc3(1'b1, DW'(301), 1'b0, 1'b0);
    cyc3(1'b1, DW'(302), 1'b1, 1'b1);
    cyc3(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream at occ=1, checked before any clock edge.
    cyc3(1'b1, DW'(400), 1'b0, 1'b0);
    u3.rsp_valid_d0 = 1'b0;
    chk("pre_arst_occ", DW'(u3.rsp_occ), DW'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", DW'(u3.rsp_valid_d1), DW'(0));
    chk("arst_ready", DW'(u3.rsp_ready_d0), DW'(1));
    chk("arst_occ",   DW'(u3.rsp_occ),      DW'(0));
    chk("arst_afull", DW'(u3.rsp_afull),    DW'(0));
    m_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc3(1'b1, DW'(500 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc3(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
